// File: rtl/mips_pipe_pkg.sv
// Shared opcodes, instruction classes and pipeline-register layouts for mips_pipe_core.
package mips_pipe_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0a;
    localparam logic [5:0] OP_SUBI  = 6'h0b;
    localparam logic [5:0] OP_SLTI  = 6'h0c;
    localparam logic [5:0] OP_BNEQZ = 6'h0d;
    localparam logic [5:0] OP_BEQZ  = 6'h0e;
    localparam logic [5:0] OP_HLT   = 6'h3f;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} instr_class_t;
    typedef enum logic [1:0] {FWD_NONE, FWD_MEM, FWD_WB} fwd_sel_t;

    // Register indices are held zero-extended to 5 bits regardless of NREG.
    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
    } if_id_t;

    typedef struct packed {
        logic         valid;
        logic [5:0]   op;
        instr_class_t cls;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   dest;
        logic         wr;
    } id_ex_t;

    typedef struct packed {
        logic         valid;
        instr_class_t cls;
        logic [4:0]   dest;
        logic         wr;
    } ex_mem_t;

    typedef struct packed {
        logic         valid;
        instr_class_t cls;
        logic [4:0]   dest;
        logic         wr;
    } mem_wb_t;

    function automatic instr_class_t op_class(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

endpackage

// File: rtl/mips_pipe_hazard.sv
// Stall / squash / forwarding-select logic for mips_pipe_core.
// Forwarding is built only when MIPS_PIPE_FWD_EN is defined; otherwise ID interlocks on EX/MEM writers.
import mips_pipe_pkg::*;

module mips_pipe_hazard (
    input  logic         id_valid,
    input  instr_class_t id_cls,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  id_ex_t       ex,
    input  ex_mem_t      mem,
    input  mem_wb_t      wb,
    input  logic         branch_taken,
    output logic         stall,
    output logic         squash,
    output fwd_sel_t     fwd_a,
    output fwd_sel_t     fwd_b
);

    logic use_a, use_b, load_use, raw;
    logic unused_ctrl;

    // Some control fields only matter in one build flavour.
    assign unused_ctrl = ^{ex, mem, wb};

    always_comb begin
        use_a    = id_valid && (id_cls inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH}) && id_rs != 5'd0;
        use_b    = id_valid && (id_cls inside {RR_ALU, STORE}) && id_rt != 5'd0;
        load_use = ex.valid && ex.cls == LOAD && ex.wr &&
                   ((use_a && ex.dest == id_rs) || (use_b && ex.dest == id_rt));
`ifdef MIPS_PIPE_FWD_EN
        raw   = load_use;
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        // EX/MEM holds only an address for loads, so it never sources a load result.
        if (mem.valid && mem.wr && mem.cls != LOAD && mem.dest == ex.rs) fwd_a = FWD_MEM;
        else if (wb.valid && wb.wr && wb.dest == ex.rs)                   fwd_a = FWD_WB;
        if (mem.valid && mem.wr && mem.cls != LOAD && mem.dest == ex.rt) fwd_b = FWD_MEM;
        else if (wb.valid && wb.wr && wb.dest == ex.rt)                   fwd_b = FWD_WB;
`else
        raw   = load_use ||
                (ex.valid && ex.wr && ((use_a && ex.dest == id_rs) || (use_b && ex.dest == id_rt))) ||
                (mem.valid && mem.wr && ((use_a && mem.dest == id_rs) || (use_b && mem.dest == id_rt)));
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
`endif
        squash = branch_taken;
        stall  = raw && !branch_taken;
    end

endmodule

// File: rtl/mips_pipe_core.sv
// Single-clock 5-stage MIPS32-subset pipeline with external instruction/data memories.
// Operand forwarding is enabled by defining MIPS_PIPE_FWD_EN.
import mips_pipe_pkg::*;

module mips_pipe_core #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int IADDR_W = 10,
    parameter int DADDR_W = 10,
    localparam int RW     = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic               dmem_we,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               halted,
    output logic               retire_valid,
    input  logic [RW-1:0]      dbg_raddr,
    output logic [XLEN-1:0]    dbg_rdata
);

    logic [IADDR_W-1:0] pc, if_npc, ex_npc, br_target;
    if_id_t             if_id;
    id_ex_t             id_ex, id_ctrl;
    ex_mem_t            ex_mem;
    mem_wb_t            mem_wb;
    logic [XLEN-1:0]    ex_a, ex_b, ex_imm, mem_alu, mem_b, wb_data;
    logic [XLEN-1:0]    regs [NREG];
    logic               halted_q, halt_pending;

    logic [5:0]         id_op;
    instr_class_t       id_cls;
    logic [4:0]         id_rd;
    logic [XLEN-1:0]    id_a, id_b, id_imm, op_a, op_b, alu, mem_result;
    logic               wb_we, fetch_stop, branch_taken, stall, squash;
    fwd_sel_t           fwd_a, fwd_b;

    // ---------------- ID: decode and register read with WB write-through
    always_comb begin
        id_op          = if_id.ir[31:26];
        id_cls         = op_class(id_op);
        id_rd          = 5'(if_id.ir[11 +: RW]);
        id_ctrl        = '0;
        id_ctrl.valid  = if_id.valid;
        id_ctrl.op     = id_op;
        id_ctrl.cls    = id_cls;
        id_ctrl.rs     = 5'(if_id.ir[21 +: RW]);
        id_ctrl.rt     = 5'(if_id.ir[16 +: RW]);
        id_ctrl.dest   = (id_cls == RR_ALU) ? id_rd : id_ctrl.rt;
        id_ctrl.wr     = (id_cls inside {RR_ALU, RM_ALU, LOAD}) && id_ctrl.dest != 5'd0;
        id_imm         = XLEN'($signed(if_id.ir[15:0]));
        wb_we          = mem_wb.valid && mem_wb.wr && !halted_q;
        id_a           = regs[id_ctrl.rs[RW-1:0]];
        id_b           = regs[id_ctrl.rt[RW-1:0]];
        if (wb_we && mem_wb.dest == id_ctrl.rs) id_a = wb_data;
        if (wb_we && mem_wb.dest == id_ctrl.rt) id_b = wb_data;
    end

    mips_pipe_hazard u_hazard (
        .id_valid     (if_id.valid),
        .id_cls       (id_cls),
        .id_rs        (id_ctrl.rs),
        .id_rt        (id_ctrl.rt),
        .ex           (id_ex),
        .mem          (ex_mem),
        .wb           (mem_wb),
        .branch_taken (branch_taken),
        .stall        (stall),
        .squash       (squash),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    // ---------------- EX: operand select, ALU, branch resolution
    always_comb begin
        op_a = (fwd_a == FWD_MEM) ? mem_alu : (fwd_a == FWD_WB) ? wb_data : ex_a;
        op_b = (fwd_b == FWD_MEM) ? mem_alu : (fwd_b == FWD_WB) ? wb_data : ex_b;
        alu  = '0;
        case (id_ex.op)
            OP_ADD:                alu = op_a + op_b;
            OP_SUB:                alu = op_a - op_b;
            OP_AND:                alu = op_a & op_b;
            OP_OR:                 alu = op_a | op_b;
            OP_SLT:                alu = XLEN'($signed(op_a) < $signed(op_b));
            OP_MUL:                alu = op_a * op_b;
            OP_ADDI, OP_LW, OP_SW: alu = op_a + ex_imm;
            OP_SUBI:               alu = op_a - ex_imm;
            OP_SLTI:               alu = XLEN'($signed(op_a) < $signed(ex_imm));
            default:               alu = '0;
        endcase
        branch_taken = id_ex.valid && id_ex.cls == BRANCH &&
                       ((id_ex.op == OP_BEQZ) == (op_a == '0));
        br_target    = ex_npc + ex_imm[IADDR_W-1:0];
    end

    // ---------------- MEM / WB
    assign dmem_addr    = mem_alu[DADDR_W-1:0];
    assign dmem_wdata   = mem_b;
    assign dmem_we      = ex_mem.valid && ex_mem.cls == STORE && !halted_q;
    assign mem_result   = (ex_mem.cls == LOAD) ? dmem_rdata : mem_alu;
    assign halted       = halted_q || (mem_wb.valid && mem_wb.cls == HALT);
    assign retire_valid = mem_wb.valid && !halted_q;
    assign imem_addr    = pc;
    assign dbg_rdata    = regs[dbg_raddr];
    assign fetch_stop   = halt_pending || (if_id.valid && id_cls == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= '0;
            if_id        <= '0;
            if_npc       <= '0;
            id_ex        <= '0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_imm       <= '0;
            ex_npc       <= '0;
            ex_mem       <= '0;
            mem_alu      <= '0;
            mem_b        <= '0;
            mem_wb       <= '0;
            wb_data      <= '0;
            halted_q     <= 1'b0;
            halt_pending <= 1'b0;
        end else if (!halted_q) begin
            halted_q <= halted;
            // A taken branch outranks both the load-use hold and an ID-stage HLT.
            if (squash) begin
                pc          <= br_target;
                if_id.valid <= 1'b0;
            end else if (stall) begin
                pc <= pc;
            end else if (fetch_stop) begin
                if_id.valid <= 1'b0;
            end else begin
                pc     <= pc + 1'b1;
                if_id  <= '{valid: 1'b1, ir: imem_rdata};
                if_npc <= pc + 1'b1;
            end
            if (if_id.valid && id_cls == HALT && !squash) halt_pending <= 1'b1;

            if (squash || stall) begin
                id_ex <= '0;
            end else begin
                id_ex  <= id_ctrl;
                ex_a   <= id_a;
                ex_b   <= id_b;
                ex_imm <= id_imm;
                ex_npc <= if_npc;
            end

            ex_mem  <= '{valid: id_ex.valid, cls: id_ex.cls, dest: id_ex.dest, wr: id_ex.wr};
            mem_alu <= alu;
            mem_b   <= op_b;
            mem_wb  <= '{valid: ex_mem.valid, cls: ex_mem.cls, dest: ex_mem.dest, wr: ex_mem.wr};
            wb_data <= mem_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[mem_wb.dest[RW-1:0]] <= wb_data;
        end
    end

endmodule

// File: tb/tb_mips_pipe_core.sv
// Self-checking bench for mips_pipe_core: directed programs plus random programs vs an ISA-level model.
module tb_mips_pipe_core;
    localparam int XLEN = 32, NREG = 32, IADDR_W = 10, DADDR_W = 10;

    localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, ANDO = 6'd2, ORO = 6'd3, SLT = 6'd4, MUL = 6'd5;
    localparam logic [5:0] LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11, SLTI = 6'd12;
    localparam logic [5:0] BNEQZ = 6'd13, BEQZ = 6'd14, HLT = 6'd63;

`ifdef MIPS_PIPE_FWD_EN
    localparam int RAW_STALLS = 0, LU_STALLS = 1;
`else
    localparam int RAW_STALLS = 2, LU_STALLS = 2;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [IADDR_W-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [DADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]    dmem_wdata, dmem_rdata, dbg_rdata;
    logic               dmem_we, halted, retire_valid;
    logic [4:0]         dbg_raddr = '0;

    logic [31:0]     imem [1024];
    logic [XLEN-1:0] dmem [1024];
    logic [XLEN-1:0] dinit [1024];
    logic [41:0]     st_log[$], m_stores[$];
    logic [XLEN-1:0] m_reg [32];
    logic [XLEN-1:0] m_mem [1024];
    int              m_retired, n_retire, n_tests, n_fail;

    always #5 clk = ~clk;

    mips_pipe_core #(.XLEN(XLEN), .NREG(NREG), .IADDR_W(IADDR_W), .DADDR_W(DADDR_W)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .halted(halted), .retire_valid(retire_valid), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) if (dmem_we) begin
        dmem[dmem_addr] <= dmem_wdata;
        st_log.push_back({dmem_addr, dmem_wdata});
    end

    always @(negedge clk) if (!rst && retire_valid) n_retire++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic clear_mems();
        for (int i = 0; i < 1024; i++) begin
            imem[i] = {HLT, 26'd0};
            dmem[i] = $urandom;
        end
    endtask

    // Architectural interpreter: one instruction at a time, no pipeline notion.
    task automatic model_run();
        int pc, nxt, rs, rt, rd, wd;
        logic [31:0] ir, a, b, imm, wv;
        logic [5:0] op;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_stores.delete();
        m_retired = 0;
        pc = 0;
        for (int step = 0; step < 5000; step++) begin
            ir = imem[pc]; op = ir[31:26];
            rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
            imm = {{16{ir[15]}}, ir[15:0]};
            a = m_reg[rs]; b = m_reg[rt];
            m_retired++;
            nxt = pc + 1; wd = -1; wv = '0;
            case (op)
                ADD:   begin wd = rd; wv = a + b; end
                SUB:   begin wd = rd; wv = a - b; end
                ANDO:  begin wd = rd; wv = a & b; end
                ORO:   begin wd = rd; wv = a | b; end
                SLT:   begin wd = rd; wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                MUL:   begin wd = rd; wv = a * b; end
                ADDI:  begin wd = rt; wv = a + imm; end
                SUBI:  begin wd = rt; wv = a - imm; end
                SLTI:  begin wd = rt; wv = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; end
                LW:    begin wd = rt; wv = m_mem[int'((a + imm) & 32'h3ff)]; end
                SW:    begin
                    m_mem[int'((a + imm) & 32'h3ff)] = b;
                    m_stores.push_back({10'((a + imm) & 32'h3ff), b});
                end
                BNEQZ: if (a != 0) nxt = pc + 1 + int'($signed(ir[15:0]));
                BEQZ:  if (a == 0) nxt = pc + 1 + int'($signed(ir[15:0]));
                default: ;
            endcase
            if (wd > 0) m_reg[wd] = wv;
            if (op == HLT) break;
            pc = nxt & 1023;
        end
    endtask

    task automatic run_prog(input string name, input int exp_edges);
        int edges;
        bit done;
        for (int i = 0; i < 1024; i++) m_mem[i] = dmem[i];
        model_run();
        rst = 1'b1;
        st_log.delete();
        n_retire = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk({name, ":pc0"}, 64'(imem_addr), 64'd0);
        edges = 0; done = 0;
        while (!done && edges < 3000) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (halted) done = 1;
        end
        chk({name, ":halt_seen"}, 64'(done), 64'd1);
        if (exp_edges >= 0) chk({name, ":cycles"}, 64'(edges), 64'(exp_edges));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk({name, ":no_retire_after_halt"}, 64'(retire_valid), 64'd0);
        end
        chk({name, ":halted_sticky"}, 64'(halted), 64'd1);
        chk({name, ":retired"}, 64'(n_retire), 64'(m_retired));
        chk({name, ":n_stores"}, 64'(st_log.size()), 64'(m_stores.size()));
        for (int i = 0; i < st_log.size() && i < m_stores.size(); i++)
            chk($sformatf("%s:store%0d", name, i), 64'(st_log[i]), 64'(m_stores[i]));
        for (int i = 0; i < 32; i++) begin
            dbg_raddr = 5'(i);
            #1 chk($sformatf("%s:r%0d", name, i), 64'(dbg_rdata), 64'(m_reg[i]));
        end
    endtask

    task automatic gen_prog(input int len, input bit allow_br);
        int r, rs, rt, rd;
        for (int i = 0; i < len; i++) begin
            r  = $urandom_range(0, 99);
            rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
            if (r < 35)      imem[i] = enc_r(6'($urandom_range(0, 5)), rs, rt, rd);
            else if (r < 55) imem[i] = enc_i(6'($urandom_range(10, 12)), rs, rt, $urandom_range(0, 4000) - 2000);
            else if (r < 68) imem[i] = enc_i(LW, rs, rt, $urandom_range(0, 31));
            else if (r < 80) imem[i] = enc_i(SW, rs, rt, $urandom_range(0, 31));
            else if (r < 92 && allow_br)
                imem[i] = enc_i(($urandom_range(0, 1) != 0) ? BEQZ : BNEQZ, rs, 0, $urandom_range(0, 3));
            else             imem[i] = enc_r(6'($urandom_range(16, 62)), rs, rt, rd);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_retire = 0;
        clear_mems();
        #12;
        chk("rst:imem_addr", 64'(imem_addr), 64'd0);
        chk("rst:halted", 64'(halted), 64'd0);
        chk("rst:retire_valid", 64'(retire_valid), 64'd0);
        chk("rst:dmem_we", 64'(dmem_we), 64'd0);

        // RAW chain
        clear_mems();
        imem[0] = enc_i(ADDI, 0, 1, 10);
        imem[1] = enc_i(ADDI, 0, 2, 20);
        imem[2] = enc_r(ADD, 1, 2, 3);
        run_prog("raw", 7 + RAW_STALLS);
        chk("raw:r3_is_30", 64'(m_reg[3]), 64'd30);

        // Load-use
        clear_mems();
        dmem[5] = 32'd7;
        imem[0] = enc_i(LW, 0, 4, 5);
        imem[1] = enc_r(ADD, 4, 4, 5);
        run_prog("loaduse", 6 + LU_STALLS);

        // Countdown loop with branch shadow
        clear_mems();
        imem[0] = enc_i(ADDI, 0, 1, 3);
        imem[1] = enc_i(SUBI, 1, 1, 1);
        imem[2] = enc_i(BNEQZ, 1, 0, -2);
        imem[3] = enc_i(ADDI, 0, 6, 1);
        run_prog("loop", -1);
        chk("loop:model_retired_9", 64'(m_retired), 64'd9);

        // Halt shadow
        clear_mems();
        imem[1] = enc_i(ADDI, 0, 7, 5);
        run_prog("hltshadow", -1);

        // Store with forwarded data
        clear_mems();
        imem[0] = enc_i(ADDI, 0, 8, 99);
        imem[1] = enc_i(SW, 0, 8, 3);
        run_prog("store", -1);
        chk("store:expected_entry", 64'(m_stores.size()), 64'd1);

        // Random programs
        for (int p = 0; p < 10; p++) begin
            clear_mems();
            gen_prog($urandom_range(10, 24), 1'b1);
            run_prog($sformatf("rnd%0d", p), -1);
        end

        // Reset asserted with the pipeline full
        clear_mems();
        imem[0] = enc_i(ADDI, 0, 1, 77);
        imem[1] = enc_i(ADDI, 0, 2, 5);
        gen_prog(30, 1'b0);
        imem[0] = enc_i(ADDI, 0, 1, 77);
        imem[1] = enc_i(ADDI, 0, 2, 5);
        for (int i = 0; i < 1024; i++) dinit[i] = dmem[i];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid:imem_addr", 64'(imem_addr), 64'd0);
        chk("rstmid:dmem_we", 64'(dmem_we), 64'd0);
        chk("rstmid:retire_valid", 64'(retire_valid), 64'd0);
        chk("rstmid:halted", 64'(halted), 64'd0);
        dbg_raddr = 5'd1;
        #1 chk("rstmid:r1_cleared", 64'(dbg_rdata), 64'd0);
        for (int i = 0; i < 1024; i++) dmem[i] = dinit[i];
        run_prog("rstmid", -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
